// File: rtl/hs_lane_sequencer.sv
// HS data-lane sequencer: HS-zero, sync byte, handshaked payload, HS-trail into the DEFF DDR flop.
// Optional macro HS_MSB_FIRST_EN selects MSB-first bit order (default LSB first).
module hs_lane_sequencer #(
  parameter int unsigned ZERO_CYCLES  = 8,
  parameter int unsigned TRAIL_CYCLES = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic       TX_DDR_clk,
  input  logic       TX_rst_n,
  input  logic       HS_req,
  input  logic [7:0] Byte_data,
  input  logic       Byte_valid,
  output logic       Byte_ready,
  output logic       Enable,
  output logic       Serial_B1,
  output logic       Serial_B2,
  output logic       HS_busy
);

  typedef enum logic [2:0] {IDLE, ZERO, SYNC, DATA, TRAIL} state_t;

  localparam logic [7:0] ZERO_LAST  = 8'(ZERO_CYCLES - 1);
  localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYCLES - 1);

  state_t     state;
  logic [1:0] pair_cnt;
  logic [7:0] cyc_cnt;
  logic [7:0] shift_reg;
  logic       req_seen;

  // Returns {Serial_B1, Serial_B2} for pair k of byte b.
  function automatic logic [1:0] pair_bits(input logic [7:0] b, input logic [1:0] k);
`ifdef HS_MSB_FIRST_EN
    return {b[3'd7 - {k, 1'b0}], b[3'd6 - {k, 1'b0}]};
`else
    return {b[{k, 1'b0}], b[{k, 1'b1}]};
`endif
  endfunction

  assign Byte_ready = ((state == SYNC) || (state == DATA)) && (pair_cnt == 2'd3);

  // A request seen in IDLE is latched first, so ZERO starts one edge after sampling.
  always_ff @(posedge TX_DDR_clk) begin
    if (!TX_rst_n) begin
      state     <= IDLE;
      pair_cnt  <= '0;
      cyc_cnt   <= '0;
      shift_reg <= '0;
      req_seen  <= 1'b0;
      Enable    <= 1'b0;
      Serial_B1 <= 1'b0;
      Serial_B2 <= 1'b0;
      HS_busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_seen) begin
            state                  <= ZERO;
            req_seen               <= 1'b0;
            cyc_cnt                <= '0;
            Enable                 <= 1'b1;
            HS_busy                <= 1'b1;
            {Serial_B1, Serial_B2} <= 2'b00;
          end else begin
            req_seen <= HS_req;
          end
        end
        ZERO: begin
          if (cyc_cnt == ZERO_LAST) begin
            state                  <= SYNC;
            shift_reg              <= SYNC_BYTE;
            pair_cnt               <= '0;
            {Serial_B1, Serial_B2} <= pair_bits(SYNC_BYTE, 2'd0);
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        SYNC, DATA: begin
          if (pair_cnt != 2'd3) begin
            pair_cnt               <= pair_cnt + 2'd1;
            {Serial_B1, Serial_B2} <= pair_bits(shift_reg, pair_cnt + 2'd1);
          end else if (Byte_valid) begin
            state                  <= DATA;
            shift_reg              <= Byte_data;
            pair_cnt               <= '0;
            {Serial_B1, Serial_B2} <= pair_bits(Byte_data, 2'd0);
          end else begin
            // Trail level is the inverse of the last bit sent, which sits in Serial_B2.
            state     <= TRAIL;
            cyc_cnt   <= '0;
            Serial_B1 <= ~Serial_B2;
            Serial_B2 <= ~Serial_B2;
          end
        end
        TRAIL: begin
          if (cyc_cnt == TRAIL_LAST) begin
            state     <= IDLE;
            Enable    <= 1'b0;
            HS_busy   <= 1'b0;
            Serial_B1 <= 1'b0;
            Serial_B2 <= 1'b0;
          end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
